ps2_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (set-LEDs 0xED, echo 0xEE, reset 0xFF, and so on) to the keyboard on the same PS/2 lines that the receive path listens on. The block drives the bus open-drain through output-enable signals, generates start, odd-parity and stop framing, and checks the device acknowledge. It sits beside the PS/2 receiver; `busy` tells the receive path to ignore bus activity while a transfer is in progress.

---
 rtl/ps2_tx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter
//
// Sends one command byte to a PS/2 device using the open-drain bus
// sequence: inhibit the clock, request-to-send (data low), release the
// clock, shift the frame out on device falling edges, then check the
// device acknowledge and wait for the bus to return idle.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before the request
//   TIMEOUT_CYCLES  clk cycles allowed from the request to end of transfer
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tx_valid     command byte offered
//   tx_data      command byte
//   tx_ready     idle; byte accepted on tx_valid && tx_ready
//   ps2_clk_in   debounced PS/2 clock line level
//   ps2_data_in  PS/2 data line level
//   ps2_clk_oe   1 pulls the PS/2 clock low
//   ps2_data_oe  1 pulls the PS/2 data low
//   busy         transfer in progress (receive path should ignore the bus)
//   tx_done      one-cycle pulse, byte acknowledged by the device
//   tx_err       one-cycle pulse, NACK or timeout

module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic          cur, prev;
    logic [9:0]    shift, shift_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ack_ok, ack_ok_nxt;
    logic          data_oe_nxt;
    logic          done_nxt, err_nxt;
    logic          ready_nxt, busy_nxt, clk_oe_nxt;

    logic neg_edge;
    logic accept;
    logic timeout;

    assign neg_edge = prev & ~cur;
    assign accept   = tx_valid & tx_ready;
    // The counter is cleared entering REQ and advances every cycle from
    // then on, so it holds TO_LAST on the TIMEOUT_CYCLES-th edge after REQ.
    assign timeout  = (cnt == TO_LAST);

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        cnt_nxt     = cnt;
        ack_ok_nxt  = ack_ok;
        data_oe_nxt = ps2_data_oe;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                data_oe_nxt = 1'b0;
                if (accept) begin
                    // Stop bit at the top so it falls out after parity;
                    // the start bit is driven directly by REQ.
                    shift_nxt   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_nxt = 4'd0;
                    cnt_nxt     = '0;
                    ack_ok_nxt  = 1'b0;
                    state_nxt   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_nxt     = '0;
                    data_oe_nxt = 1'b1;
                    state_nxt   = S_REQ;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            S_REQ: begin
                cnt_nxt   = cnt + CNT_ONE;
                state_nxt = S_SEND;
            end

            S_SEND: begin
                if (timeout) begin
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (neg_edge) begin
                        data_oe_nxt = ~shift[0];
                        shift_nxt   = {1'b0, shift[9:1]};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        // The tenth edge puts the stop bit (line released).
                        if (bit_cnt == 4'd9) begin
                            state_nxt = S_WAIT_ACK;
                        end
                    end
                end
            end

            S_WAIT_ACK: begin
                if (timeout) begin
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (neg_edge) begin
                        ack_ok_nxt = ~ps2_data_in;
                        state_nxt  = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (timeout) begin
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (ps2_clk_in && ps2_data_in) begin
                        done_nxt  = ack_ok;
                        err_nxt   = ~ack_ok;
                        state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                data_oe_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase

        clk_oe_nxt = (state_nxt == S_INHIBIT) || (state_nxt == S_REQ);
        busy_nxt   = (state_nxt != S_IDLE);
        // Ready stays low through the completion pulse so a byte offered
        // in that cycle is not taken; it returns on the following cycle.
        ready_nxt  = (state_nxt == S_IDLE) && !done_nxt && !err_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur         <= 1'b0;
            prev        <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            cnt         <= '0;
            ack_ok      <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur         <= ps2_clk_in;
            prev        <= cur;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            cnt         <= cnt_nxt;
            ack_ok      <= ack_ok_nxt;
            tx_ready    <= ready_nxt;
            busy        <= busy_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            tx_done     <= done_nxt;
            tx_err      <= err_nxt;
        end
    end

endmodule
